// File: rtl/netlist_bist.sv
// netlist_bist: LFSR-driven BIST engine for a combinational netlist.
// Compacts netlist responses into a MISR and checks against golden.
module netlist_bist #(
  parameter int unsigned PATTERNS  = 1023,
  parameter logic [9:0]  SEED      = 10'h001,
  parameter logic [15:0] MISR_SEED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] golden,
  input  logic [3:0]  resp,
  output logic [9:0]  stim,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  // An all-zero seed would lock the LFSR, so fall back to 1.
  localparam logic [9:0] SEED_EFF =
    (SEED == 10'd0) ? 10'h001 : SEED;
  localparam logic [9:0] LAST = 10'(PATTERNS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [9:0]  stim_d;
  logic [15:0] sig_d;
  logic [9:0]  cnt_q;
  logic [9:0]  cnt_d;
  logic        pass_d;
  logic [9:0]  lfsr_nxt;
  logic        fb;
  logic [15:0] misr_nxt;

  assign lfsr_nxt = {stim[8:0], stim[9] ^ stim[6]};
  assign fb = signature[15] ^ signature[13]
            ^ signature[12] ^ signature[10];
  assign misr_nxt = {signature[14:0], fb} ^ {12'b0, resp};

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // State, pattern, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      stim      <= '0;
      signature <= '0;
      cnt_q     <= '0;
      pass      <= 1'b0;
    end else begin
      state_q   <= state_d;
      stim      <= stim_d;
      signature <= sig_d;
      cnt_q     <= cnt_d;
      pass      <= pass_d;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    stim_d  = stim;
    sig_d   = signature;
    cnt_d   = cnt_q;
    pass_d  = pass;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          stim_d  = SEED_EFF;
          sig_d   = MISR_SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          stim_d  = '0;
        end else begin
          sig_d = misr_nxt;
          if (cnt_q == LAST) begin
            state_d = DONE;
            stim_d  = '0;
            pass_d  = (misr_nxt == golden);
          end else begin
            stim_d = lfsr_nxt;
            cnt_d  = cnt_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_netlist_bist.sv
// tb_netlist_bist: self-checking bench for netlist_bist.
// Three instances cover short, seed-zero and full-period runs.
module tb_netlist_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        start8 = 0, abort8 = 0;
  logic [15:0] golden8 = 0;
  logic [3:0]  resp8 = 0;
  logic [9:0]  stim8;
  logic        busy8, done8, pass8;
  logic [15:0] sig8;

  logic        start2 = 0, abort2 = 0;
  logic [15:0] golden2 = 0;
  logic [3:0]  resp2 = 0;
  logic [9:0]  stim2;
  logic        busy2, done2, pass2;
  logic [15:0] sig2;

  logic        startf = 0, abortf = 0;
  logic [15:0] goldenf = 0;
  logic [3:0]  respf = 0;
  logic [9:0]  stimf;
  logic        busyf, donef, passf;
  logic [15:0] sigf;

  netlist_bist #(.PATTERNS(8), .SEED(10'h001)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .abort(abort8), .golden(golden8), .resp(resp8),
    .stim(stim8), .busy(busy8), .done(done8),
    .pass(pass8), .signature(sig8)
  );

  netlist_bist #(.PATTERNS(2), .SEED(10'h000)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .abort(abort2), .golden(golden2), .resp(resp2),
    .stim(stim2), .busy(busy2), .done(done2),
    .pass(pass2), .signature(sig2)
  );

  netlist_bist #(.PATTERNS(1023)) uf (
    .clk(clk), .rst_n(rst_n), .start(startf),
    .abort(abortf), .golden(goldenf), .resp(respf),
    .stim(stimf), .busy(busyf), .done(donef),
    .pass(passf), .signature(sigf)
  );

  // Reference model: polynomial rules written as plain arithmetic.
  function automatic int m_lfsr(input int s);
    int bit_in;
    bit_in = ((s / 512) ^ (s / 64)) % 2;
    return (s * 2) % 1024 + bit_in;
  endfunction

  function automatic int m_misr(input int sig, input int r);
    int fb;
    fb = $countones(sig & 32'hB400) % 2;
    return ((sig * 2) % 65536 + fb) ^ r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  resp;
    logic [15:0] golden;
    logic [15:0] s1;
    logic [15:0] s2;
    logic        pass;
  } vec_t;

  // Random 8-pattern run with model signature and golden.
  task automatic run8(input bit match, input bit poke);
    int sm;
    sm = 0;
    @(negedge clk);
    start8 = 1;
    golden8 = 16'($urandom);
    @(negedge clk);
    start8 = 0;
    chk("run8_done_clr", done8, 0);
    chk("run8_pass_clr", pass8, 0);
    chk("run8_stim0", stim8, 10'h001);
    for (int i = 0; i < 8; i++) begin
      resp8 = 4'($urandom);
      sm = m_misr(sm, int'(resp8));
      if (i == 7)
        golden8 = match ? 16'(sm)
                : 16'(sm) ^ 16'($urandom_range(1, 65535));
      start8 = (poke && i == 3);
      @(negedge clk);
    end
    start8 = 0;
    chk("run8_done", done8, 1);
    chk("run8_sig", sig8, 16'(sm));
    chk("run8_pass", pass8, match);
  endtask

  logic [9:0] seq8 [8];
  vec_t       vt [4];
  bit         seen [1024];
  int         sm, sq, bcnt, bad_stim, bad_seq;

  initial begin
    seq8 = '{10'h001, 10'h002, 10'h004, 10'h008,
             10'h010, 10'h020, 10'h040, 10'h081};
    vt[0] = '{4'hF, 16'h0011, 16'h000F, 16'h0011, 1'b1};
    vt[1] = '{4'hF, 16'h0012, 16'h000F, 16'h0011, 1'b0};
    vt[2] = '{4'h0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vt[3] = '{4'h1, 16'h0003, 16'h0001, 16'h0003, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stim", stim8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_pass", pass8, 0);
    chk("rst_sig", sig8, 0);
    rst_n = 1;

    // Pattern sequence
    @(negedge clk);
    start8 = 1;
    @(negedge clk);
    start8 = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("seq_stim%0d", i), stim8, seq8[i]);
      chk($sformatf("seq_busy%0d", i), busy8, 1);
      @(negedge clk);
    end
    chk("seq_done", done8, 1);
    chk("seq_stim_end", stim8, 0);
    chk("seq_busy_end", busy8, 0);

    // Signature table on the 2-pattern, zero-seed instance
    for (int k = 0; k < 4; k++) begin
      resp2 = vt[k].resp;
      golden2 = vt[k].golden;
      start2 = 1;
      @(negedge clk);
      start2 = 0;
      chk("tab_seed_sub", stim2, 10'h001);
      chk("tab_sig0", sig2, 0);
      @(negedge clk);
      chk("tab_sig1", sig2, vt[k].s1);
      chk("tab_nodone1", done2, 0);
      @(negedge clk);
      chk("tab_sig2", sig2, vt[k].s2);
      chk("tab_done", done2, 1);
      chk("tab_pass", pass2, vt[k].pass);
    end

    // Random runs, back-to-back, ignored start in RUN
    run8(1, 0);
    run8(0, 0);
    run8(1, 1);
    run8(0, 1);

    // Abort together with start at RUN cycle 5
    @(negedge clk);
    start8 = 1;
    @(negedge clk);
    start8 = 0;
    sm = 0;
    for (int i = 0; i < 5; i++) begin
      resp8 = 4'($urandom);
      sm = m_misr(sm, int'(resp8));
      @(negedge clk);
    end
    abort8 = 1;
    start8 = 1;
    resp8 = 4'($urandom);
    @(negedge clk);
    abort8 = 0;
    start8 = 0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_stim", stim8, 0);
    chk("abort_sig", sig8, 16'(sm));
    @(negedge clk);
    chk("abort_idle", busy8, 0);
    chk("abort_sig_hold", sig8, 16'(sm));
    run8(1, 0);
    abort8 = 1;
    @(negedge clk);
    abort8 = 0;
    chk("abort_in_done", done8, 1);
    chk("abort_in_done_pass", pass8, 1);

    // Full period with random responses
    startf = 1;
    @(negedge clk);
    startf = 0;
    sm = 0;
    sq = 1;
    bcnt = 0;
    bad_stim = 0;
    bad_seq = 0;
    for (int i = 0; i < 1024; i++) seen[i] = 0;
    for (int i = 0; i < 1023; i++) begin
      if (busyf) bcnt++;
      if (stimf == 0 || seen[stimf]) bad_stim++;
      seen[stimf] = 1;
      if (int'(stimf) != sq) bad_seq++;
      sq = m_lfsr(sq);
      if (donef) bad_seq++;
      respf = 4'($urandom);
      sm = m_misr(sm, int'(respf));
      if (i == 1022) goldenf = 16'(sm);
      @(negedge clk);
    end
    chk("full_distinct", bad_stim, 0);
    chk("full_lfsr_seq", bad_seq, 0);
    chk("full_busy_cnt", bcnt, 1023);
    chk("full_done", donef, 1);
    chk("full_sig", sigf, 16'(sm));
    chk("full_pass", passf, 1);

    // Asynchronous reset mid-run
    startf = 1;
    @(negedge clk);
    startf = 0;
    repeat (100) begin
      respf = 4'($urandom);
      @(negedge clk);
    end
    chk("mid_busy_pre", busyf, 1);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_stim", stimf, 0);
    chk("mid_rst_busy", busyf, 0);
    chk("mid_rst_done", donef, 0);
    chk("mid_rst_pass", passf, 0);
    chk("mid_rst_sig", sigf, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busyf, 0);
    chk("post_rst_done", donef, 0);
    chk("post_rst_stim", stimf, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
